// File: rtl/cursor_step_gen_pkg.sv
// Shared types and constants for the cursor step generator: screen geometry,
// default timing, axis FSM encoding and button bit positions.
package cursor_step_gen_pkg;

   localparam int SCREEN_X_WIDTH    = 640;
   localparam int SCREEN_Y_WIDTH    = 480;
   localparam int SCREEN_X_BITWIDTH = 9;
   localparam int SCREEN_Y_BITWIDTH = 8;
   localparam int X_COORD_W         = SCREEN_X_BITWIDTH + 1;
   localparam int Y_COORD_W         = SCREEN_Y_BITWIDTH + 1;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 1024;
   localparam int DEF_REPEAT_PERIOD   = 256;

   // Bit positions inside the held vector {up,down,left,right}
   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_UP    = 3;

   typedef enum logic [1:0] {
      AXIS_IDLE   = 2'd0,
      AXIS_DELAY  = 2'd1,
      AXIS_REPEAT = 2'd2
   } axis_state_t;

   // Counter width able to hold (largest load - 1); never narrower than 1 bit.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cursor_step_gen_if.sv
// Button, coordinate and step-pulse bundle between the pixel mover side and
// the step generator.
interface cursor_step_gen_if;
   import cursor_step_gen_pkg::*;

   logic                 enable;
   logic                 btn_right;
   logic                 btn_left;
   logic                 btn_down;
   logic                 btn_up;
   logic [X_COORD_W-1:0] x_coord;
   logic [Y_COORD_W-1:0] y_coord;
   logic                 x_inc;
   logic                 x_dec;
   logic                 y_inc;
   logic                 y_dec;
   logic [3:0]           held;

   modport master (
      output enable, btn_right, btn_left, btn_down, btn_up, x_coord, y_coord,
      input  x_inc, x_dec, y_inc, y_dec, held
   );

   modport slave (
      input  enable, btn_right, btn_left, btn_down, btn_up, x_coord, y_coord,
      output x_inc, x_dec, y_inc, y_dec, held
   );

endinterface

// File: rtl/cursor_step_gen_axis_repeat_fsm.sv
// Per-axis first-step / delay / auto-repeat sequencer with edge-of-screen
// suppression of the registered step pulses.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   AXIS_IDLE   | no single direction active; waits for exactly one held
//   AXIS_DELAY  | first step issued, counting down to the first repeat
//   AXIS_REPEAT | issuing one step per repeat period while held unchanged
module axis_repeat_fsm
   import cursor_step_gen_pkg::*;
#(
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int COORD_W       = X_COORD_W,
   parameter int COORD_MAX     = SCREEN_X_WIDTH - 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               inc_held,
   input  logic               dec_held,
   input  logic [COORD_W-1:0] coord,
   output logic               inc_pulse,
   output logic               dec_pulse
);

   localparam int                 TMR_W       = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [TMR_W-1:0]   DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0]   PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);
   localparam logic [COORD_W-1:0] COORD_LIMIT = COORD_W'(COORD_MAX);

   axis_state_t      state;
   logic [TMR_W-1:0] timer;
   logic             run_inc;

   logic single;
   logic hold_ok;
   logic inc_room;
   logic dec_room;

   assign single   = inc_held ^ dec_held;
   // Staying active needs the very direction that started the run.
   assign hold_ok  = enable && single && (inc_held == run_inc);
   assign inc_room = coord < COORD_LIMIT;
   assign dec_room = coord != '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= AXIS_IDLE;
         timer     <= '0;
         run_inc   <= 1'b0;
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
      end else begin
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
         case (state)
            AXIS_IDLE: begin
               if (enable && single) begin
                  state     <= AXIS_DELAY;
                  timer     <= DELAY_LOAD;
                  run_inc   <= inc_held;
                  inc_pulse <= inc_held && inc_room;
                  dec_pulse <= !inc_held && dec_room;
               end
            end
            AXIS_DELAY, AXIS_REPEAT: begin
               if (!hold_ok) begin
                  state <= AXIS_IDLE;
                  timer <= '0;
               end else if (timer == '0) begin
                  // Pulse is suppressed at the edge but the cadence keeps running.
                  state     <= AXIS_REPEAT;
                  timer     <= PERIOD_LOAD;
                  inc_pulse <= run_inc && inc_room;
                  dec_pulse <= !run_inc && dec_room;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            default: begin
               state <= AXIS_IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cursor_step_gen.sv
// Cursor step generator: synchronizes and debounces four direction buttons,
// then drives one auto-repeat sequencer per axis.
module cursor_step_gen
   import cursor_step_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int X_MAX           = SCREEN_X_WIDTH - 1,
   parameter int Y_MAX           = SCREEN_Y_WIDTH - 1
) (
   input  logic               clock,
   input  logic               reset,
   cursor_step_gen_if.slave   bus
);

   localparam int              DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0] btn_raw;
   logic [3:0] level;
   logic       x_inc_q;
   logic       x_dec_q;
   logic       y_inc_q;
   logic       y_dec_q;

   assign btn_raw[BTN_RIGHT] = bus.btn_right;
   assign btn_raw[BTN_LEFT]  = bus.btn_left;
   assign btn_raw[BTN_DOWN]  = bus.btn_down;
   assign btn_raw[BTN_UP]    = bus.btn_up;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_db
         logic            sync_a;
         logic            sync_b;
         logic            lvl;
         logic [DB_W-1:0] cnt;

         // Counter reloads on any agreeing cycle; level flips when it reaches zero.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sync_a <= 1'b0;
               sync_b <= 1'b0;
               lvl    <= 1'b0;
               cnt    <= DB_LOAD;
            end else begin
               sync_a <= btn_raw[i];
               sync_b <= sync_a;
               if (sync_b == lvl) begin
                  cnt <= DB_LOAD;
               end else if (cnt == '0) begin
                  lvl <= sync_b;
                  cnt <= DB_LOAD;
               end else begin
                  cnt <= cnt - DB_W'(1);
               end
            end
         end

         assign level[i] = lvl;
      end
   endgenerate

   axis_repeat_fsm #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .COORD_W       (X_COORD_W),
      .COORD_MAX     (X_MAX)
   ) u_x_axis (
      .clock     (clock),
      .reset     (reset),
      .enable    (bus.enable),
      .inc_held  (level[BTN_RIGHT]),
      .dec_held  (level[BTN_LEFT]),
      .coord     (bus.x_coord),
      .inc_pulse (x_inc_q),
      .dec_pulse (x_dec_q)
   );

   axis_repeat_fsm #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .COORD_W       (Y_COORD_W),
      .COORD_MAX     (Y_MAX)
   ) u_y_axis (
      .clock     (clock),
      .reset     (reset),
      .enable    (bus.enable),
      .inc_held  (level[BTN_DOWN]),
      .dec_held  (level[BTN_UP]),
      .coord     (bus.y_coord),
      .inc_pulse (y_inc_q),
      .dec_pulse (y_dec_q)
   );

   assign bus.x_inc = x_inc_q;
   assign bus.x_dec = x_dec_q;
   assign bus.y_inc = y_inc_q;
   assign bus.y_dec = y_dec_q;
   assign bus.held  = level;

endmodule

// File: tb/tb_cursor_step_gen.sv
// Scoreboard bench for cursor_step_gen: a run-age reference model predicts
// step pulses and debounced levels; a negedge monitor compares them.
module tb_cursor_step_gen;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 5;
   localparam int XM = 639;
   localparam int YM = 479;

   logic clock;
   logic reset;

   cursor_step_gen_if u_if ();

   cursor_step_gen #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .X_MAX           (XM),
      .Y_MAX           (YM)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      logic [3:0] vec;   // {x_inc, x_dec, y_inc, y_dec}
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   n_p[4];         // observed pulse counts: 3=x_inc 2=x_dec 1=y_inc 0=y_dec

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: debounce by consecutive-difference run length, axes by
   // age since first step of the current single-direction run.
   logic [3:0] m_s1, m_s2, m_lvl, m_nxt, m_vec;
   int         m_run[4];
   bit         ax_active[2];
   int         ax_dir[2];
   int         ax_age[2];
   bit         m_hi, m_lo, m_fire;
   int         m_dir, m_crd, m_lim;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0;
         for (int b = 0; b < 4; b++) m_run[b] = 0;
         for (int a = 0; a < 2; a++) begin
            ax_active[a] = 0; ax_dir[a] = 0; ax_age[a] = 0;
         end
         exp_q.delete();
      end else begin
         cyc++;
         m_nxt = m_lvl;
         for (int b = 0; b < 4; b++) begin
            if (m_s2[b] != m_lvl[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_nxt[b] = m_s2[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = {u_if.btn_up, u_if.btn_down, u_if.btn_left, u_if.btn_right};
         m_vec = '0;
         for (int a = 0; a < 2; a++) begin
            m_hi   = m_lvl[2*a];
            m_lo   = m_lvl[2*a+1];
            m_dir  = m_hi ? 1 : -1;
            m_fire = 0;
            if (!u_if.enable || (m_hi == m_lo) || (ax_active[a] && m_dir != ax_dir[a])) begin
               ax_active[a] = 0;
            end else if (!ax_active[a]) begin
               ax_active[a] = 1; ax_dir[a] = m_dir; ax_age[a] = 0; m_fire = 1;
            end else begin
               ax_age[a]++;
               m_fire = (ax_age[a] >= RD) && (((ax_age[a] - RD) % RP) == 0);
            end
            m_crd = (a == 0) ? int'(u_if.x_coord) : int'(u_if.y_coord);
            m_lim = (a == 0) ? XM : YM;
            if (m_fire && m_dir == 1 && m_crd < m_lim) m_vec[3-2*a] = 1'b1;
            if (m_fire && m_dir == -1 && m_crd != 0)   m_vec[2-2*a] = 1'b1;
         end
         m_lvl = m_nxt;
         if (m_vec != '0) exp_q.push_back('{cyc, m_vec});
      end
   end

   logic [3:0] mon_vec;
   always @(negedge clock) begin
      mon_vec = {u_if.x_inc, u_if.x_dec, u_if.y_inc, u_if.y_dec};
      if (!reset) begin
         check("outputs_in_reset", int'({mon_vec, u_if.held}), 0);
      end else begin
         for (int k = 0; k < 4; k++) if (mon_vec[k]) n_p[k]++;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missing_pulse", 0, int'(exp_q[0].vec));
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("pulse_vec", int'(mon_vec), int'(exp_q[0].vec));
            void'(exp_q.pop_front());
         end else begin
            check("stray_pulse", int'(mon_vec), 0);
         end
         check("held", int'(u_if.held), int'(m_lvl));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic set_btn(input logic [3:0] b);   // {up,down,left,right}
      u_if.btn_up    = b[3];
      u_if.btn_down  = b[2];
      u_if.btn_left  = b[1];
      u_if.btn_right = b[0];
   endtask

   int base[4];
   task automatic snap();
      for (int k = 0; k < 4; k++) base[k] = n_p[k];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int sel;
   initial begin
      for (int k = 0; k < 4; k++) n_p[k] = 0;
      reset = 1'b0;
      u_if.enable = 1'b1;
      set_btn(4'b0000);
      u_if.x_coord = 10'd100;
      u_if.y_coord = 9'd100;
      tick(3);
      check("held_after_reset", int'(u_if.held), 0);
      reset = 1'b1;
      tick(5);

      // Short glitch never reaches the debounced level
      snap();
      set_btn(4'b0001); tick(3); set_btn(4'b0000); tick(12);
      check("glitch_x_inc", n_p[3] - base[3], 0);
      check("glitch_held", int'(u_if.held), 0);

      // Long right hold: first step then 20, 25, 30 ... until release
      snap();
      set_btn(4'b0001); tick(60); set_btn(4'b0000); tick(15);
      check("hold60_x_inc_count", n_p[3] - base[3], 9);
      check("hold60_x_dec_count", n_p[2] - base[2], 0);

      // Both X directions held, then right released
      snap();
      set_btn(4'b0011); tick(40);
      check("both_held_x_pulses", n_p[3] + n_p[2] - base[3] - base[2], 0);
      set_btn(4'b0010); tick(40); set_btn(4'b0000); tick(15);
      check("left_after_both_x_dec", n_p[2] - base[2], 5);
      check("left_after_both_x_inc", n_p[3] - base[3], 0);

      // Edge suppression on both axes
      snap();
      u_if.x_coord = 10'd639; u_if.y_coord = 9'd0;
      set_btn(4'b1001); tick(40); set_btn(4'b0000); tick(15);
      check("edge_x_inc", n_p[3] - base[3], 0);
      check("edge_y_dec", n_p[0] - base[0], 0);
      u_if.x_coord = 10'd100; u_if.y_coord = 9'd100;

      // Reset in the middle of repeat, button still held afterwards
      set_btn(4'b0001); tick(40);
      reset = 1'b0; #1;
      check("reset_immediate", int'({u_if.x_inc, u_if.x_dec, u_if.y_inc, u_if.y_dec, u_if.held}), 0);
      tick(3);
      reset = 1'b1;
      snap();
      tick(6);
      check("redebounce_no_pulse", n_p[3] - base[3], 0);
      tick(2);
      check("redebounce_first_pulse", n_p[3] - base[3], 1);
      set_btn(4'b0000); tick(15);

      // Enable low during a down hold, then enable restores stepping at once
      set_btn(4'b0100); tick(10);
      u_if.enable = 1'b0;
      snap();
      tick(30);
      check("disabled_y_inc", n_p[1] - base[1], 0);
      u_if.enable = 1'b1;
      tick(1);
      check("enable_first_step", int'(u_if.y_inc), 1);
      tick(40); set_btn(4'b0000); tick(15);

      // Randomized phase
      for (int it = 0; it < 200; it++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) set_btn(4'($urandom_range(0, 15)));
         else          set_btn(4'(1 << $urandom_range(0, 3)));
         u_if.enable = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 5))
            0: begin u_if.x_coord = 10'd0;   u_if.y_coord = 9'd0;   end
            1: begin u_if.x_coord = 10'd1;   u_if.y_coord = 9'd1;   end
            2: begin u_if.x_coord = 10'd638; u_if.y_coord = 9'd478; end
            3: begin u_if.x_coord = 10'd639; u_if.y_coord = 9'd479; end
            4: begin u_if.x_coord = 10'd700; u_if.y_coord = 9'd490; end
            default: begin
               u_if.x_coord = 10'($urandom_range(0, XM - 1));
               u_if.y_coord = 9'($urandom_range(0, YM - 1));
            end
         endcase
         tick($urandom_range(1, 45));
      end

      set_btn(4'b0000);
      u_if.enable = 1'b1;
      tick(60);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
